// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit (1), WIDTH data bits, stop bit (0), sampled on EN strobes.
// Good frames update PO with a one-cycle VALID pulse; a bad stop bit gives a one-cycle ERR pulse.
module serial_frame_rx #(
    parameter int WIDTH = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SI,
    input  logic             EN,
    input  logic             LR,
    output logic [WIDTH-1:0] PO,
    output logic             VALID,
    output logic             ERR,
    output logic             BUSY
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lrl_q, lrl_d;
    logic [WIDTH-1:0]   po_q, po_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            lrl_q   <= 1'b0;
            po_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            lrl_q   <= lrl_d;
            po_q    <= po_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Everything holds between strobes; only the pulse outputs fall back to 0.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        lrl_d   = lrl_q;
        po_d    = po_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (EN) begin
            case (state_q)
                ST_IDLE: begin
                    if (SI) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        sh_d    = '0;
                        lrl_d   = LR;
                    end
                end
                ST_DATA: begin
                    if (lrl_q) begin
                        sh_d = {sh_q[WIDTH-2:0], SI};
                    end else begin
                        sh_d = {SI, sh_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    // A 1 here is a framing error, never a new start bit.
                    state_d = ST_IDLE;
                    if (SI) begin
                        err_d = 1'b1;
                    end else begin
                        po_d    = sh_q;
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign PO    = po_q;
    assign VALID = valid_q;
    assign ERR   = err_q;
    assign BUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames plus random frames checked against a
// frame-level model (expected word from send order and bit-order mode).
module tb_serial_frame_rx;

  localparam int W = 5;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         SI  = 1'b0;
  logic         EN  = 1'b0;
  logic         LR  = 1'b0;
  logic [W-1:0] PO;
  logic         VALID;
  logic         ERR;
  logic         BUSY;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_po = '0;

  serial_frame_rx #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .SI    (SI),
    .EN    (EN),
    .LR    (LR),
    .PO    (PO),
    .VALID (VALID),
    .ERR   (ERR),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic si, input logic en, input logic lr, input logic rst);
    @(negedge CLK);
    SI  = si;
    EN  = en;
    LR  = lr;
    RST = rst;
    @(posedge CLK);
    #1;
  endtask

  // Word the receiver should hold: first-sent bit is the MSB in MSB-first mode, the LSB otherwise.
  function automatic logic [W-1:0] model_word(input logic [W-1:0] seq, input logic lr);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      r[i] = lr ? seq[i] : seq[W-1-i];
    end
    return r;
  endfunction

  // seq[W-1] is sent first. gap = idle (EN=0) cycles before every strobe.
  task automatic send_frame(input logic [W-1:0] seq, input logic lr, input logic stop_bit,
                            input int gap, input logic toggle_lr);
    logic bit_v;
    logic lr_v;
    for (int j = 0; j < W + 2; j++) begin
      for (int g = 0; g < gap; g++) begin
        tick(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        check("gap_busy", {31'd0, BUSY}, {31'd0, (j > 0)});
        check("gap_valid", {31'd0, VALID}, 32'd0);
        check("gap_err", {31'd0, ERR}, 32'd0);
        check("gap_po", {{(32-W){1'b0}}, PO}, {{(32-W){1'b0}}, exp_po});
      end
      if (j == 0) bit_v = 1'b1;
      else if (j == W + 1) bit_v = stop_bit;
      else bit_v = seq[W-j];
      lr_v = (j != 0 && toggle_lr) ? 1'($urandom_range(0, 1)) : lr;
      tick(bit_v, 1'b1, lr_v, 1'b1);
      if (j < W + 1) begin
        check("frame_busy", {31'd0, BUSY}, 32'd1);
        check("frame_valid", {31'd0, VALID}, 32'd0);
        check("frame_err", {31'd0, ERR}, 32'd0);
        check("frame_po_hold", {{(32-W){1'b0}}, PO}, {{(32-W){1'b0}}, exp_po});
      end else begin
        if (!stop_bit) exp_po = model_word(seq, lr);
        check("stop_valid", {31'd0, VALID}, {31'd0, !stop_bit});
        check("stop_err", {31'd0, ERR}, {31'd0, stop_bit});
        check("stop_busy", {31'd0, BUSY}, 32'd0);
        check("stop_po", {{(32-W){1'b0}}, PO}, {{(32-W){1'b0}}, exp_po});
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valid"}, {31'd0, VALID}, 32'd0);
    check({tag, "_err"}, {31'd0, ERR}, 32'd0);
    check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
    check({tag, "_po"}, {{(32-W){1'b0}}, PO}, {{(32-W){1'b0}}, exp_po});
  endtask

  initial begin
    // Reset with SI toggling and EN high.
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    exp_po = '0;
    check_quiet("reset");

    // SI=1 without a strobe is not a start bit.
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    check_quiet("no_strobe_idle");
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    check_quiet("idle_zero");

    // MSB-first frame, data 10110.
    send_frame(5'b10110, 1'b1, 1'b0, 0, 1'b0);
    check("msb_po", {27'd0, PO}, {27'd0, 5'b10110});
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    check_quiet("msb_after");

    // LSB-first frame, same line bits, LR toggled mid-frame.
    send_frame(5'b10110, 1'b0, 1'b0, 0, 1'b1);
    check("lsb_po", {27'd0, PO}, {27'd0, 5'b01101});
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    check_quiet("lsb_after");

    // Framing error after a good frame; then an immediate fresh start.
    send_frame(5'b10110, 1'b1, 1'b0, 0, 1'b0);
    send_frame(5'b00000, 1'b1, 1'b1, 0, 1'b0);
    check("err_po_kept", {27'd0, PO}, {27'd0, 5'b10110});
    send_frame(5'b01011, 1'b1, 1'b0, 0, 1'b0);
    check("after_err_po", {27'd0, PO}, {27'd0, 5'b01011});

    // Gapped strobe: EN every 3rd cycle.
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    send_frame(5'b10011, 1'b1, 1'b0, 2, 1'b0);
    check("gap_po_final", {27'd0, PO}, {27'd0, 5'b10011});
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    check_quiet("gap_after");

    // Reset mid-frame after 3 data bits.
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    check("mid_busy_before", {31'd0, BUSY}, 32'd1);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    exp_po = '0;
    check_quiet("mid_reset");
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      check_quiet("post_reset_idle");
    end
    send_frame(5'b11100, 1'b1, 1'b0, 0, 1'b0);
    check("post_reset_po", {27'd0, PO}, {27'd0, 5'b11100});

    // Random frames: data, order, stop bit, gap and mid-frame LR noise.
    for (int n = 0; n < 30; n++) begin
      send_frame(W'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        check_quiet("rand_idle");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Framed serial receiver (deserializer) that collects bits from a one-bit serial line, such as a shift-register output, and presents them as a parallel word. A frame is one start bit (1), WIDTH data bits, and one stop bit (0). The line idles at 0. Bits are sampled only on cycles where the bit strobe EN is high. The block reports each completed word with a one-cycle VALID pulse and each bad stop bit with a one-cycle ERR pulse.

## Interface
- WIDTH, 5, data bits per frame; legal range is 2 or more.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-low; it has priority over every other input.
- SI  in  1  serial data line.
- EN  in  1  bit strobe; SI is sampled only on edges where EN=1.
- LR  in  1  bit order; 1 = MSB first (bits enter at LSB and shift left), 0 = LSB first (bits enter at MSB and shift right). LR is latched when the start bit is sampled.
- PO  out  WIDTH  last good received word; holds until the next good frame.
- VALID  out  1  one-cycle pulse; PO was updated on this edge.
- ERR  out  1  one-cycle pulse; framing error (stop bit was 1).
- BUSY  out  1  high while a frame is in progress (state is not IDLE).

## Operation
- Internal state:
  - shift register SH[WIDTH-1:0];
  - bit counter CNT, ceil(log2(WIDTH)) bits;
  - latched order bit LRL;
  - FSM with states IDLE, DATA, STOP.
- Reset (RST=0 at an edge) sets: state to IDLE, SH=0, CNT=0, LRL=0, PO=0, VALID=0, ERR=0. BUSY follows state, so it reads 0.
- VALID and ERR are registered. They default to 0 on every edge unless set as described below.
- Edges with EN=0: state, SH, CNT, LRL and PO hold. VALID and ERR still return to 0.
- IDLE, EN=1:
  - SI=1: this is a start bit. Go to DATA, set CNT=0 and SH=0, and latch LRL=LR.
  - SI=0: stay in IDLE.
- DATA, EN=1:
  - if LRL=1, SH <= {SH[WIDTH-2:0], SI};
  - if LRL=0, SH <= {SI, SH[WIDTH-1:1]};
  - if CNT==WIDTH-1, go to STOP; otherwise CNT <= CNT+1.
- STOP, EN=1:
  - SI=0: PO <= SH, VALID <= 1, go to IDLE.
  - SI=1: ERR <= 1, PO unchanged, go to IDLE. This 1 is not treated as a new start bit.
- LR changes while BUSY=1 are ignored; only LRL is used for the frame.
- SI has no effect unless EN=1.

## Timing
- Let the start bit be sampled at edge k (EN=1 on every cycle):
  - data bits are sampled at edges k+1 .. k+WIDTH;
  - the stop bit is sampled at edge k+WIDTH+1;
  - PO and VALID (or ERR) change at edge k+WIDTH+1 and are visible for exactly one cycle after it.
- With a gapped EN, latency is counted in EN strobes: WIDTH+2 strobes from the start bit through the stop bit.
- BUSY rises after edge k and falls after the stop-bit edge.
- Back-to-back frames: a start bit may be sampled on the strobe immediately after the stop bit, with no idle gap required.
- VALID and ERR never assert together. Each asserts at most once per frame.
- Reset mid-frame aborts the frame:
  - no VALID or ERR pulse;
  - PO becomes 0 on the reset edge;
  - a new start bit is accepted on the first EN=1 edge with RST=1.

## Test plan
- Reset: hold RST=0 for 2 edges while SI toggles and EN=1 -> after the edges, PO=5'b00000 and VALID=ERR=BUSY=0; SI toggling during reset has no effect.
- MSB-first frame: WIDTH=5, LR=1, EN=1, SI sequence 1,1,0,1,1,0,0 (start, data 10110, stop) -> after the 7th edge, PO=5'b10110 and VALID=1 for one cycle; BUSY=1 over edges 1..6.
- LSB-first frame: LR=0, SI sequence 1,1,0,1,1,0,0 -> PO=5'b01101 and VALID pulses once. Toggle LR mid-frame; PO must still be 5'b01101.
- Framing error: after a good frame leaves PO=5'b10110, send SI 1,0,0,0,0,0,1 (stop bit = 1) -> ERR pulses for one cycle, VALID stays 0, and PO stays 5'b10110. The next edge with SI=1 must be treated as a fresh start.
- Gapped strobe: EN=1 only on every 3rd cycle, LR=1, frame data 10011 -> PO=5'b10011 and exactly one VALID pulse, on the stop-bit strobe edge. State holds on non-strobe cycles even when SI changes.
- Reset mid-frame: drop RST=0 for one edge after 3 data bits -> PO=0, BUSY=0, no VALID or ERR pulse. Then send a full frame with data 11100, LR=1 -> PO=5'b11100 and VALID pulses once.
